// File: rtl/ha_array_pkg.sv
// Shared widths, FSM states and row-weighting constants for the ha_array accumulator.
package ha_array_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned T_W      = 9;
  localparam int unsigned B_W      = 7;
  localparam int unsigned P_W      = 16;
  localparam int unsigned ROW_W    = 10;
  localparam int unsigned ACC_W    = 17;
  localparam int unsigned CNT_W    = $clog2(NUM_ROWS);

  // b bits sit two positions above t bits; consecutive rows are 4x apart.
  localparam int unsigned B_OFS     = 2;
  localparam int unsigned ROW_SHIFT = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/ha_array_accumulator_row.sv
// Combinational value of one half-adder row pair: t + (b << 2).
module ha_row_value
  import ha_array_pkg::*;
(
  input  logic [T_W-1:0]   t_i,
  input  logic [B_W-1:0]   b_i,
  output logic [ROW_W-1:0] row_o
);

  assign row_o = ROW_W'(t_i) + (ROW_W'(b_i) << B_OFS);

endmodule

// File: rtl/ha_array_accumulator.sv
// Sequential Horner reduction of four ha_array row pairs into a 16-bit product,
// one row per cycle from the most significant row down.
module ha_array_accumulator
  import ha_array_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [T_W-1:0] ha_array_3_t,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [B_W-1:0] ha_array_3_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_product,
  output logic           out_ovf
);

  state_e                         state_q, state_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NUM_ROWS-1:0][T_W-1:0]   t_q, t_d;
  logic [NUM_ROWS-1:0][B_W-1:0]   b_q, b_d;
  logic [NUM_ROWS-1:0][T_W-1:0]   t_in;
  logic [NUM_ROWS-1:0][B_W-1:0]   b_in;
  logic [ROW_W-1:0]               row_val;
  logic                           load;

  assign t_in = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
  assign b_in = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};

  ha_row_value u_row_value (
    .t_i   (t_q[cnt_q]),
    .b_i   (b_q[cnt_q]),
    .row_o (row_val)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    b_d       = b_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;

    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      StAcc: begin
        acc_d = (acc_q << ROW_SHIFT) + ACC_W'(row_val);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        // Result and new row set may change hands on the same edge.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      t_d     = t_in;
      b_d     = b_in;
      acc_d   = '0;
      cnt_d   = CNT_W'(NUM_ROWS - 1);
      state_d = StAcc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      t_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      b_q     <= b_d;
    end
  end

  assign out_product = acc_q[P_W-1:0];
  assign out_ovf     = acc_q[P_W];

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Directed table-driven bench for ha_array_accumulator plus stall, back-to-back and
// mid-operation reset sequences.
module tb_ha_array_accumulator;

  typedef struct packed {
    logic [3:0][8:0] t;
    logic [3:0][6:0] b;
    logic [15:0]     exp_product;
    logic            exp_ovf;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0][8:0] t_in;
  logic [3:0][6:0] b_in;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_product;
  logic            out_ovf;

  int checks   = 0;
  int failures = 0;
  int lat;
  vec_t vecs [7];

  always #5 clk = ~clk;

  ha_array_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (t_in[0]),
    .ha_array_1_t (t_in[1]),
    .ha_array_2_t (t_in[2]),
    .ha_array_3_t (t_in[3]),
    .ha_array_0_b (b_in[0]),
    .ha_array_1_b (b_in[1]),
    .ha_array_2_b (b_in[2]),
    .ha_array_3_b (b_in[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .out_ovf      (out_ovf)
  );

  // Reference half-adder array: row k combines x*y[2k] and (x*y[2k+1]) << 1.
  function automatic vec_t mk_exact(input logic [7:0] x, input logic [7:0] y,
                                    input logic [15:0] p);
    vec_t v;
    logic [7:0] a;
    logic [7:0] c;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      a = x & {8{y[2*k]}};
      c = x & {8{y[2*k+1]}};
      v.t[k][0] = a[0];
      for (int i = 1; i < 8; i++) begin
        v.t[k][i]   = a[i] ^ c[i-1];
        v.b[k][i-1] = a[i] & c[i-1];
      end
      v.t[k][8] = c[7];
    end
    v.exp_product = p;
    v.exp_ovf     = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic scramble();
    t_in = 36'({$urandom(), $urandom()});
    b_in = 28'($urandom());
  endtask

  task automatic send(input vec_t v);
    t_in     = v.t;
    b_in     = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '0;
    vecs[1] = '0; vecs[1].t[0] = 9'h001; vecs[1].exp_product = 16'd1;
    vecs[2] = '0; vecs[2].b[3] = 7'h40;  vecs[2].exp_product = 16'd16384;
    vecs[3] = mk_exact(8'hFF, 8'hFF, 16'd65025);
    vecs[4] = mk_exact(8'd13, 8'd11, 16'd143);
    vecs[5].t = {4{9'h1FF}};
    vecs[5].b = {4{7'h7F}};
    vecs[5].exp_product = 16'd21079;
    vecs[5].exp_ovf     = 1'b1;
    vecs[6] = '0; vecs[6].t[2] = 9'h100; vecs[6].exp_product = 16'd4096;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; t_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_product", 32'(out_product), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      send(vecs[i]);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_product", i), 32'(out_product), 32'(vecs[i].exp_product));
      check($sformatf("v%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].exp_ovf));
      consume();
    end

    // Stall in DONE for three cycles, then back-to-back accept.
    send(vecs[4]);
    wait_valid(lat);
    check("stall_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_product", 32'(out_product), 32'd143);
      check("stall_ovf", 32'(out_ovf), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    t_in      = vecs[3].t;
    b_in      = vecs[3].b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    scramble();
    check("b2b_out_valid_drop", 32'(out_valid), 32'd0);
    check("b2b_busy_in_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
    check("b2b_latency", 32'(lat), 32'd4);
    check("b2b_product", 32'(out_product), 32'd65025);
    check("b2b_ovf", 32'(out_ovf), 32'd0);
    consume();

    // Asynchronous reset during the second ACC cycle.
    send(vecs[5]);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_product", 32'(out_product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(vecs[4]);
    wait_valid(lat);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_product", 32'(out_product), 32'd143);
    check("post_rst_ovf", 32'(out_ovf), 32'd0);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
